mesa_tx_arb: RTL and testbench

MESA_TX_ARB -- requirements
Module: mesa_tx_arb

---
 rtl/mesa_tx_arb.sv | 201 ++++++++++++++++++++
 tb/tb_mesa_tx_arb.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mesa_tx_arb.sv
// -----------------------------------------------------------------------------
// mesa_tx_arb
//   Two-requester arbiter that hands the single byte-to-ASCII transmit path to
//   one requester at a time. The owner's bytes are registered onto the
//   downstream strobe. Its end-of-message flag is forwarded the same way. The
//   grant is revoked after TIMEOUT idle cycles. Once a message finishes, the
//   arbiter lingers in DRAIN so the converter can emit its trailing line feed.
//
// Ports
//   clk, reset                      clock, asynchronous active-high reset
//   rq{0,1}_req                     request the transmit path
//   rq{0,1}_grant                   path owned by that requester
//   rq{0,1}_byte_d / _byte_en       byte and its strobe
//   rq{0,1}_byte_busy               do not strobe (constant 1 when not owner)
//   rq{0,1}_byte_done               end of message
//   tx_byte_d / _en / _done         byte, strobe, message-end pulse downstream
//   tx_byte_busy                    converter busy
//   timeout_err                     one-cycle pulse when a grant is revoked
//   ovr_err                         one-cycle pulse when an owner byte is dropped
// -----------------------------------------------------------------------------
module mesa_tx_arb #(
  parameter int TIMEOUT = 1024
) (
  input  logic       clk,
  input  logic       reset,

  input  logic       rq0_req,
  output logic       rq0_grant,
  input  logic [7:0] rq0_byte_d,
  input  logic       rq0_byte_en,
  output logic       rq0_byte_busy,
  input  logic       rq0_byte_done,

  input  logic       rq1_req,
  output logic       rq1_grant,
  input  logic [7:0] rq1_byte_d,
  input  logic       rq1_byte_en,
  output logic       rq1_byte_busy,
  input  logic       rq1_byte_done,

  output logic [7:0] tx_byte_d,
  output logic       tx_byte_en,
  output logic       tx_byte_done,
  input  logic       tx_byte_busy,

  output logic       timeout_err,
  output logic       ovr_err
);

  localparam int               CNT_W     = $clog2(TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN0  = 2'd1,
    OWN1  = 2'd2,
    DRAIN = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic             last_q, last_d;      // requester served most recently
  logic [CNT_W-1:0] cnt_q, cnt_d;        // idle cycles of the current owner
  logic [1:0]       drain_q, drain_d;    // cycles spent in DRAIN, saturates at 2
  logic [7:0]       tx_d_q, tx_d_d;
  logic             tx_en_q, tx_en_d;
  logic             tx_done_q, tx_done_d;
  logic             tout_q, tout_d;
  logic             ovr_q, ovr_d;
  logic             grant0_q, grant0_d;
  logic             grant1_q, grant1_d;

  // Owner-side view of the two requesters.
  logic       own_valid;
  logic       own_sel;
  logic [7:0] own_d;
  logic       own_en;
  logic       own_done;
  logic       path_busy;
  logic       accept;
  logic       drop;

  assign own_valid = (state_q == OWN0) || (state_q == OWN1);
  assign own_sel   = (state_q == OWN1);
  assign own_d     = own_sel ? rq1_byte_d    : rq0_byte_d;
  assign own_en    = own_sel ? rq1_byte_en   : rq0_byte_en;
  assign own_done  = own_sel ? rq1_byte_done : rq0_byte_done;

  // The byte registered last cycle still occupies the path this cycle.
  assign path_busy = tx_byte_busy | tx_en_q;
  assign accept    = own_valid & own_en & ~path_busy;
  assign drop      = own_valid & own_en &  path_busy;

  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    state_d   = state_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    drain_d   = drain_q;
    tx_d_d    = accept ? own_d : tx_d_q;
    tx_en_d   = accept;
    tx_done_d = 1'b0;
    tout_d    = 1'b0;
    ovr_d     = drop;

    unique case (state_q)
      IDLE: begin
        cnt_d   = '0;
        drain_d = 2'd0;
        if (rq0_req && rq1_req) begin
          state_d = last_q ? OWN0 : OWN1;
        end else if (rq0_req) begin
          state_d = OWN0;
        end else if (rq1_req) begin
          state_d = OWN1;
        end
      end

      OWN0, OWN1: begin
        if (own_done) begin
          tx_done_d = 1'b1;
          last_d    = own_sel;
          drain_d   = 2'd0;
          state_d   = DRAIN;
        end else if (accept) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_LIMIT) begin
          tx_done_d = 1'b1;
          tout_d    = 1'b1;
          last_d    = own_sel;
          drain_d   = 2'd0;
          state_d   = DRAIN;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      DRAIN: begin
        cnt_d = '0;
        // Give the converter at least two cycles to start its line feed,
        // then wait for it to go quiet.
        if ((drain_q == 2'd2) && !tx_byte_busy) begin
          state_d = IDLE;
        end else if (drain_q != 2'd2) begin
          drain_d = drain_q + 2'd1;
        end
      end

      default: state_d = IDLE;
    endcase

    grant0_d = (state_d == OWN0);
    grant1_d = (state_d == OWN1);
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      last_q    <= 1'b1;
      cnt_q     <= '0;
      drain_q   <= 2'd0;
      tx_d_q    <= 8'h00;
      tx_en_q   <= 1'b0;
      tx_done_q <= 1'b0;
      tout_q    <= 1'b0;
      ovr_q     <= 1'b0;
      grant0_q  <= 1'b0;
      grant1_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      drain_q   <= drain_d;
      tx_d_q    <= tx_d_d;
      tx_en_q   <= tx_en_d;
      tx_done_q <= tx_done_d;
      tout_q    <= tout_d;
      ovr_q     <= ovr_d;
      grant0_q  <= grant0_d;
      grant1_q  <= grant1_d;
    end
  end

  assign rq0_grant     = grant0_q;
  assign rq1_grant     = grant1_q;
  assign tx_byte_d     = tx_d_q;
  assign tx_byte_en    = tx_en_q;
  assign tx_byte_done  = tx_done_q;
  assign timeout_err   = tout_q;
  assign ovr_err       = ovr_q;

  // The owner sees back-pressure including its own strobe this cycle.
  // Everyone else is told the path is busy.
  assign rq0_byte_busy = (state_q == OWN0) ? (path_busy | rq0_byte_en) : 1'b1;
  assign rq1_byte_busy = (state_q == OWN1) ? (path_busy | rq1_byte_en) : 1'b1;

endmodule

// File: tb/tb_mesa_tx_arb.sv
// -----------------------------------------------------------------------------
// tb_mesa_tx_arb
//   Scoreboard bench for mesa_tx_arb. The driver applies directed and
//   randomized stimulus. For every cycle it advances a transaction-level model
//   of the arbiter. The model pushes the expected downstream activity into a
//   queue. A separate monitor pops and compares whenever the DUT shows
//   activity.
// -----------------------------------------------------------------------------
module tb_mesa_tx_arb;

  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       rq0_req, rq1_req;
  logic       rq0_grant, rq1_grant;
  logic [7:0] rq0_byte_d, rq1_byte_d;
  logic       rq0_byte_en, rq1_byte_en;
  logic       rq0_byte_busy, rq1_byte_busy;
  logic       rq0_byte_done, rq1_byte_done;
  logic [7:0] tx_byte_d;
  logic       tx_byte_en, tx_byte_done, tx_byte_busy;
  logic       timeout_err, ovr_err;

  always #5 clk = ~clk;

  mesa_tx_arb #(.TIMEOUT(TO)) dut (
    .clk           (clk),
    .reset         (reset),
    .rq0_req       (rq0_req),
    .rq0_grant     (rq0_grant),
    .rq0_byte_d    (rq0_byte_d),
    .rq0_byte_en   (rq0_byte_en),
    .rq0_byte_busy (rq0_byte_busy),
    .rq0_byte_done (rq0_byte_done),
    .rq1_req       (rq1_req),
    .rq1_grant     (rq1_grant),
    .rq1_byte_d    (rq1_byte_d),
    .rq1_byte_en   (rq1_byte_en),
    .rq1_byte_busy (rq1_byte_busy),
    .rq1_byte_done (rq1_byte_done),
    .tx_byte_d     (tx_byte_d),
    .tx_byte_en    (tx_byte_en),
    .tx_byte_done  (tx_byte_done),
    .tx_byte_busy  (tx_byte_busy),
    .timeout_err   (timeout_err),
    .ovr_err       (ovr_err)
  );

  // One expected cycle of downstream activity.
  typedef struct {
    int         cyc;
    logic [1:0] grant;
    bit         en;
    logic [7:0] d;
    bit         done;
    bit         tout;
    bit         ovr;
  } ev_t;

  ev_t sb[$];
  int  gorder[$];          // owners in the order they were granted
  int  vectors     = 0;
  int  miscompares = 0;
  int  cyc         = 0;
  int  t_g1        = -1;   // cycle rq1_grant last rose
  int  t_tout      = -1;   // cycle timeout_err last pulsed

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: who holds the path, whether the path is winding down
  // after a message, and the bookkeeping needed for fairness and timeout.
  // ---------------------------------------------------------------------------
  int         m_owner;      // -1: nobody holds the path
  bit         m_drain;      // message over, waiting for the converter
  int         m_drain_age;
  int         m_last;
  int         m_idle;       // owner cycles since grant or last accepted byte
  bit         m_prev_acc;   // a byte is on tx_byte_en this cycle
  logic [1:0] m_grant;

  function automatic void model_reset();
    m_owner     = -1;
    m_drain     = 1'b0;
    m_drain_age = 0;
    m_last      = 1;
    m_idle      = 0;
    m_prev_acc  = 1'b0;
    m_grant     = 2'b00;
  endfunction

  function automatic void model_step(input bit [1:0] r, input bit [1:0] e,
                                     input logic [7:0] d0, input logic [7:0] d1,
                                     input bit [1:0] dn, input bit busy);
    ev_t        ev;
    logic [1:0] old_grant;
    bit         acc;
    int         n;
    old_grant = m_grant;
    acc       = 1'b0;
    ev.cyc    = cyc + 1;
    ev.en     = 1'b0;
    ev.d      = 8'h00;
    ev.done   = 1'b0;
    ev.tout   = 1'b0;
    ev.ovr    = 1'b0;
    if (m_owner >= 0) begin
      n = m_owner;
      if (e[n]) begin
        if (busy || m_prev_acc) ev.ovr = 1'b1;
        else begin
          acc   = 1'b1;
          ev.en = 1'b1;
          ev.d  = (n == 1) ? d1 : d0;
        end
      end
      if (dn[n] || (!acc && m_idle == TO - 1)) begin
        ev.done     = 1'b1;
        ev.tout     = !dn[n];
        m_last      = n;
        m_owner     = -1;
        m_drain     = 1'b1;
        m_drain_age = 0;
      end else if (acc) begin
        m_idle = 0;
      end else begin
        m_idle++;
      end
    end else if (m_drain) begin
      if (m_drain_age >= 2 && !busy) m_drain = 1'b0;
      else m_drain_age++;
    end else begin
      if (r[0] && r[1]) m_owner = 1 - m_last;
      else if (r[0])    m_owner = 0;
      else if (r[1])    m_owner = 1;
      m_idle = 0;
    end
    m_prev_acc = acc;
    m_grant    = (m_owner >= 0) ? 2'(1 << m_owner) : 2'b00;
    ev.grant   = m_grant;
    if (ev.en || ev.done || ev.tout || ev.ovr || (m_grant != old_grant))
      sb.push_back(ev);
  endfunction

  // ---------------------------------------------------------------------------
  // Driver: one call is one clock cycle of stimulus.
  // ---------------------------------------------------------------------------
  task automatic drive(input bit rst, input bit [1:0] r, input bit [1:0] e,
                       input logic [7:0] d0, input logic [7:0] d1,
                       input bit [1:0] dn, input bit busy);
    bit exp0, exp1;
    @(posedge clk);
    #1;
    reset         = rst;
    rq0_req       = r[0];
    rq1_req       = r[1];
    rq0_byte_en   = e[0];
    rq1_byte_en   = e[1];
    rq0_byte_d    = d0;
    rq1_byte_d    = d1;
    rq0_byte_done = dn[0];
    rq1_byte_done = dn[1];
    tx_byte_busy  = busy;
    #1;
    if (rst) begin
      model_reset();
    end else begin
      exp0 = (m_owner == 0) ? (busy | m_prev_acc | e[0]) : 1'b1;
      exp1 = (m_owner == 1) ? (busy | m_prev_acc | e[1]) : 1'b1;
      check("rq0_byte_busy", 32'(rq0_byte_busy), 32'(exp0));
      check("rq1_byte_busy", 32'(rq1_byte_busy), 32'(exp1));
      model_step(r, e, d0, d1, dn, busy);
    end
  endtask

  task automatic idle(input int n, input bit busy);
    for (int i = 0; i < n; i++) drive(1'b0, 2'b00, 2'b00, 8'h00, 8'h00, 2'b00, busy);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_tx_byte_en"},   32'(tx_byte_en),   32'd0);
    check({tag, "_tx_byte_done"}, 32'(tx_byte_done), 32'd0);
    check({tag, "_tx_byte_d"},    32'(tx_byte_d),    32'd0);
    check({tag, "_rq0_grant"},    32'(rq0_grant),    32'd0);
    check({tag, "_rq1_grant"},    32'(rq1_grant),    32'd0);
    check({tag, "_timeout_err"},  32'(timeout_err),  32'd0);
    check({tag, "_ovr_err"},      32'(ovr_err),      32'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: pops the scoreboard whenever the DUT shows activity.
  // ---------------------------------------------------------------------------
  initial begin
    logic [1:0] prev_g;
    logic [1:0] cur_g;
    ev_t        exp;
    bit         act_any;
    prev_g = 2'b00;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_g = 2'b00;
        continue;
      end
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        exp = sb.pop_front();
        vectors++;
        miscompares++;
        $display("FAIL missing_event: got nothing at cycle %0d, required grant=%b en=%b done=%b tout=%b ovr=%b",
                 exp.cyc, exp.grant, exp.en, exp.done, exp.tout, exp.ovr);
      end
      cur_g   = {rq1_grant, rq0_grant};
      act_any = tx_byte_en | tx_byte_done | timeout_err | ovr_err | (cur_g != prev_g);
      if (cur_g != prev_g && cur_g != 2'b00) gorder.push_back(rq1_grant ? 1 : 0);
      if (rq1_grant && !prev_g[1]) t_g1 = cyc;
      if (timeout_err) t_tout = cyc;
      if (act_any) begin
        if (sb.size() == 0 || sb[0].cyc != cyc) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_event: got grant=%b en=%b done=%b tout=%b ovr=%b at cycle %0d, required no activity",
                   cur_g, tx_byte_en, tx_byte_done, timeout_err, ovr_err, cyc);
        end else begin
          exp = sb.pop_front();
          check("event{grant,en,done,tout,ovr}",
                32'({cur_g, tx_byte_en, tx_byte_done, timeout_err, ovr_err}),
                32'({exp.grant, exp.en, exp.done, exp.tout, exp.ovr}));
          if (exp.en) check("tx_byte_d", 32'(tx_byte_d), 32'(exp.d));
        end
      end
      prev_g = cur_g;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    bit [1:0]   r, e, dn;
    bit         b;
    int         pe;
    int         order [3];

    reset         = 1'b1;
    rq0_req       = 1'b0;
    rq1_req       = 1'b0;
    rq0_byte_en   = 1'b0;
    rq1_byte_en   = 1'b0;
    rq0_byte_d    = 8'h00;
    rq1_byte_d    = 8'h00;
    rq0_byte_done = 1'b0;
    rq1_byte_done = 1'b0;
    tx_byte_busy  = 1'b0;
    model_reset();

    repeat (3) drive(1'b1, 2'b00, 2'b00, 8'h00, 8'h00, 2'b00, 1'b0);
    check_cleared("reset");
    check("reset_rq0_byte_busy", 32'(rq0_byte_busy), 32'd1);
    check("reset_rq1_byte_busy", 32'(rq1_byte_busy), 32'd1);

    // Single owner: two bytes paced by the converter, then message end.
    drive(1'b0, 2'b01, 2'b00, 8'h00, 8'h00, 2'b00, 1'b0);
    drive(1'b0, 2'b01, 2'b01, 8'hA5, 8'h00, 2'b00, 1'b0);
    repeat (3) drive(1'b0, 2'b01, 2'b00, 8'h00, 8'h00, 2'b00, 1'b1);
    drive(1'b0, 2'b01, 2'b01, 8'h3C, 8'h00, 2'b00, 1'b0);
    repeat (2) drive(1'b0, 2'b01, 2'b00, 8'h00, 8'h00, 2'b00, 1'b1);
    drive(1'b0, 2'b01, 2'b00, 8'h00, 8'h00, 2'b01, 1'b0);
    idle(3, 1'b1);
    idle(3, 1'b0);

    // Non-owner strobe while requester 0 holds the path.
    drive(1'b0, 2'b01, 2'b00, 8'h00, 8'h00, 2'b00, 1'b0);
    repeat (2) drive(1'b0, 2'b01, 2'b10, 8'h00, 8'h77, 2'b00, 1'b0);
    drive(1'b0, 2'b01, 2'b00, 8'h00, 8'h00, 2'b01, 1'b0);
    idle(5, 1'b0);

    // Overrun: back-to-back strobes, the second must be dropped.
    drive(1'b0, 2'b01, 2'b00, 8'h00, 8'h00, 2'b00, 1'b0);
    drive(1'b0, 2'b01, 2'b01, 8'h11, 8'h00, 2'b00, 1'b0);
    drive(1'b0, 2'b01, 2'b01, 8'h22, 8'h00, 2'b00, 1'b0);
    drive(1'b0, 2'b01, 2'b00, 8'h00, 8'h00, 2'b00, 1'b0);
    drive(1'b0, 2'b01, 2'b00, 8'h00, 8'h00, 2'b01, 1'b0);
    idle(5, 1'b0);

    // Timeout: requester 1 granted and silent.
    drive(1'b0, 2'b10, 2'b00, 8'h00, 8'h00, 2'b00, 1'b0);
    idle(22, 1'b0);
    check("timeout_latency", 32'(t_tout - t_g1), 32'd16);

    // Tie held from reset: grants rotate 0,1,0.
    repeat (2) drive(1'b1, 2'b00, 2'b00, 8'h00, 8'h00, 2'b00, 1'b0);
    gorder.delete();
    repeat (20) drive(1'b0, 2'b11, 2'b00, 8'h00, 8'h00, 2'b11, 1'b0);
    repeat (2) drive(1'b0, 2'b00, 2'b00, 8'h00, 8'h00, 2'b11, 1'b0);
    idle(6, 1'b0);
    for (int i = 0; i < 3; i++) order[i] = (i < gorder.size()) ? gorder[i] : -1;
    check("tie_grant_0", 32'(order[0]), 32'd0);
    check("tie_grant_1", 32'(order[1]), 32'd1);
    check("tie_grant_2", 32'(order[2]), 32'd0);

    // Asynchronous reset while requester 0 owns the path with a byte in flight.
    drive(1'b0, 2'b01, 2'b00, 8'h00, 8'h00, 2'b00, 1'b0);
    drive(1'b0, 2'b01, 2'b01, 8'hC3, 8'h00, 2'b00, 1'b0);
    drive(1'b0, 2'b01, 2'b00, 8'h00, 8'h00, 2'b00, 1'b0);
    drive(1'b0, 2'b01, 2'b01, 8'h5A, 8'h00, 2'b00, 1'b0);
    #1;
    reset = 1'b1;
    sb.delete();
    model_reset();
    #1;
    check_cleared("async_reset");
    repeat (2) drive(1'b1, 2'b01, 2'b00, 8'h00, 8'h00, 2'b00, 1'b0);
    gorder.delete();
    drive(1'b0, 2'b11, 2'b00, 8'h00, 8'h00, 2'b00, 1'b0);
    drive(1'b0, 2'b11, 2'b00, 8'h00, 8'h00, 2'b00, 1'b0);
    drive(1'b0, 2'b00, 2'b00, 8'h00, 8'h00, 2'b01, 1'b0);
    idle(6, 1'b0);
    order[0] = (gorder.size() > 0) ? gorder[0] : -1;
    check("post_reset_tie", 32'(order[0]), 32'd0);

    // Randomized traffic, alternating chatty and near-silent owners.
    for (int i = 0; i < 3000; i++) begin
      pe = ((i / 500) % 2 == 1) ? 3 : 40;
      r  = {bit'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 3) != 0)};
      e  = {bit'($urandom_range(0, 99) < pe), bit'($urandom_range(0, 99) < pe)};
      dn = {bit'($urandom_range(0, 29) == 0), bit'($urandom_range(0, 29) == 0)};
      b  = bit'($urandom_range(0, 3) == 0);
      drive(1'b0, r, e, 8'($urandom), 8'($urandom), dn, b);
    end

    // Let any open message time out and drain.
    idle(40, 1'b0);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
